// File: rtl/somador_desvio_pipe.sv
// ---------------------------------------------------------------------------
// somador_desvio_pipe
// Registered branch/jump target unit for the MIPS datapath.
// It computes PC+4, the relative branch target (sign-extended offset << 2),
// the j target and the jr target, and evaluates the beq/bne condition.
// Results leave through a 1- or 2-stage pipeline with valid/stall/flush.
//
// Parameters
//   LARGURA  : address/data width in bits (>= 28)
//   LATENCIA : stages from acceptance to output (1 or 2)
//
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   valido_in           : operation valid this cycle
//   stall               : freeze every stage
//   flush               : kill every in-flight operation
//   modo                : 00 beq, 01 bne, 10 j, 11 jr
//   pc, imediato,
//   indice, regA, regB  : operands of the branch/jump instruction
//   destino             : next-PC value
//   tomado              : redirect required
//   estouro             : relative target wrapped around the address space
//   valido_out          : outputs carry a valid result
// ---------------------------------------------------------------------------
module somador_desvio_pipe #(
   parameter int LARGURA  = 32,
   parameter int LATENCIA = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               valido_in,
   input  logic               stall,
   input  logic               flush,
   input  logic [1:0]         modo,
   input  logic [LARGURA-1:0] pc,
   input  logic [15:0]        imediato,
   input  logic [25:0]        indice,
   input  logic [LARGURA-1:0] regA,
   input  logic [LARGURA-1:0] regB,
   output logic [LARGURA-1:0] destino,
   output logic               tomado,
   output logic               estouro,
   output logic               valido_out
);

   logic [LARGURA-1:0] pc4;
   logic [LARGURA-1:0] desl;
   logic [LARGURA-1:0] alvo_rel;
   logic [LARGURA-1:0] alvo_j;
   logic [LARGURA-1:0] alvo_salto;
   logic               carry_rel;
   logic               wrap;
   logic               cond;
   logic               eh_salto;

   // Front end: everything that depends only on the current inputs.
   always_comb begin
      pc4  = pc + LARGURA'(4);
      desl = {{(LARGURA-18){imediato[15]}}, imediato, 2'b00};
      {carry_rel, alvo_rel} = {1'b0, pc4} + {1'b0, desl};
      // pc4 is unsigned and desl signed: the exact sum leaves the address
      // range exactly when the unsigned carry disagrees with the offset sign
      // (carry without negative offset = overflow, no carry with negative
      // offset = underflow).
      wrap       = carry_rel ^ imediato[15];
      cond       = modo[0] ? (regA != regB) : (regA == regB);
      eh_salto   = modo[1];
      alvo_salto = modo[0] ? regA : alvo_j;
   end

   generate
      if (LARGURA > 28) begin : g_j_alto
         assign alvo_j = {pc4[LARGURA-1:28], indice, 2'b00};
      end else begin : g_j_28
         assign alvo_j = {indice, 2'b00};
      end
   endgenerate

   // Final selection: returns {destino, tomado, estouro}.
   function automatic logic [LARGURA+1:0] resolve(
      input logic               f_salto,
      input logic               f_cond,
      input logic               f_wrap,
      input logic [LARGURA-1:0] f_pc4,
      input logic [LARGURA-1:0] f_rel,
      input logic [LARGURA-1:0] f_alvo_salto
   );
      logic [LARGURA-1:0] d;
      logic               t;
      logic               e;
      t = f_salto | f_cond;
      e = ~f_salto & f_cond & f_wrap;
      if (f_salto)     d = f_alvo_salto;
      else if (f_cond) d = f_rel;
      else             d = f_pc4;
      return {d, t, e};
   endfunction

   generate
      if (LATENCIA == 1) begin : g_lat1
         logic               valido_q,  valido_d;
         logic [LARGURA-1:0] destino_q, destino_d;
         logic               tomado_q,  tomado_d;
         logic               estouro_q, estouro_d;

         always_comb begin
            valido_d  = valido_q;
            destino_d = destino_q;
            tomado_d  = tomado_q;
            estouro_d = estouro_q;
            if (flush) begin
               valido_d  = 1'b0;
               destino_d = '0;
               tomado_d  = 1'b0;
               estouro_d = 1'b0;
            end else if (!stall) begin
               valido_d = valido_in;
               if (valido_in)
                  {destino_d, tomado_d, estouro_d} =
                     resolve(eh_salto, cond, wrap, pc4, alvo_rel, alvo_salto);
               else
                  {destino_d, tomado_d, estouro_d} = '0;
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               valido_q  <= 1'b0;
               destino_q <= '0;
               tomado_q  <= 1'b0;
               estouro_q <= 1'b0;
            end else begin
               valido_q  <= valido_d;
               destino_q <= destino_d;
               tomado_q  <= tomado_d;
               estouro_q <= estouro_d;
            end
         end

         assign destino    = destino_q;
         assign tomado     = tomado_q;
         assign estouro    = estouro_q;
         assign valido_out = valido_q;
      end else if (LATENCIA == 2) begin : g_lat2
         // Stage 1: pre-computed candidates and decision bits.
         logic               v1_q,        v1_d;
         logic               salto1_q,    salto1_d;
         logic               cond1_q,     cond1_d;
         logic               wrap1_q,     wrap1_d;
         logic [LARGURA-1:0] pc4_1_q,     pc4_1_d;
         logic [LARGURA-1:0] rel1_q,      rel1_d;
         logic [LARGURA-1:0] alvo1_q,     alvo1_d;
         // Stage 2: final muxed outputs.
         logic               v2_q,        v2_d;
         logic [LARGURA-1:0] destino2_q,  destino2_d;
         logic               tomado2_q,   tomado2_d;
         logic               estouro2_q,  estouro2_d;

         always_comb begin
            v1_d       = v1_q;
            salto1_d   = salto1_q;
            cond1_d    = cond1_q;
            wrap1_d    = wrap1_q;
            pc4_1_d    = pc4_1_q;
            rel1_d     = rel1_q;
            alvo1_d    = alvo1_q;
            v2_d       = v2_q;
            destino2_d = destino2_q;
            tomado2_d  = tomado2_q;
            estouro2_d = estouro2_q;
            if (flush) begin
               v1_d       = 1'b0;
               salto1_d   = 1'b0;
               cond1_d    = 1'b0;
               wrap1_d    = 1'b0;
               pc4_1_d    = '0;
               rel1_d     = '0;
               alvo1_d    = '0;
               v2_d       = 1'b0;
               destino2_d = '0;
               tomado2_d  = 1'b0;
               estouro2_d = 1'b0;
            end else if (!stall) begin
               v1_d     = valido_in;
               salto1_d = valido_in & eh_salto;
               cond1_d  = valido_in & cond;
               wrap1_d  = valido_in & wrap;
               pc4_1_d  = valido_in ? pc4        : '0;
               rel1_d   = valido_in ? alvo_rel   : '0;
               alvo1_d  = valido_in ? alvo_salto : '0;
               v2_d     = v1_q;
               if (v1_q)
                  {destino2_d, tomado2_d, estouro2_d} =
                     resolve(salto1_q, cond1_q, wrap1_q, pc4_1_q, rel1_q, alvo1_q);
               else
                  {destino2_d, tomado2_d, estouro2_d} = '0;
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               v1_q       <= 1'b0;
               salto1_q   <= 1'b0;
               cond1_q    <= 1'b0;
               wrap1_q    <= 1'b0;
               pc4_1_q    <= '0;
               rel1_q     <= '0;
               alvo1_q    <= '0;
               v2_q       <= 1'b0;
               destino2_q <= '0;
               tomado2_q  <= 1'b0;
               estouro2_q <= 1'b0;
            end else begin
               v1_q       <= v1_d;
               salto1_q   <= salto1_d;
               cond1_q    <= cond1_d;
               wrap1_q    <= wrap1_d;
               pc4_1_q    <= pc4_1_d;
               rel1_q     <= rel1_d;
               alvo1_q    <= alvo1_d;
               v2_q       <= v2_d;
               destino2_q <= destino2_d;
               tomado2_q  <= tomado2_d;
               estouro2_q <= estouro2_d;
            end
         end

         assign destino    = destino2_q;
         assign tomado     = tomado2_q;
         assign estouro    = estouro2_q;
         assign valido_out = v2_q;
      end else begin : g_latencia_invalida
         $error("somador_desvio_pipe: LATENCIA must be 1 or 2");
         assign destino    = '0;
         assign tomado     = 1'b0;
         assign estouro    = 1'b0;
         assign valido_out = 1'b0;
      end

      if (LARGURA < 28) begin : g_largura_invalida
         $error("somador_desvio_pipe: LARGURA must be >= 28");
      end
   endgenerate

endmodule
